// File: rtl/si_inst_injector.sv
// Single-instruction injector: presents one latched candidate word to fetch with a
// valid/stall handshake, then drives NOP stall words for a fixed drain window.
module si_inst_injector #(
  parameter int          DRAIN_CYCLES = 16,
  parameter logic [31:0] NOP_WORD     = 32'h0000_007F
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] inst_in,
  input  logic        fetch_stall,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  output logic        target_issued,
  output logic        check_window,
  output logic        busy,
  output logic        done,
  output logic [7:0]  stall_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TARGET = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  logic [1:0]  state_q,     state_d;
  logic [31:0] target_q,    target_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic        issued_q,    issued_d;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;
    issued_d    = issued_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d    = inst_in;
          stall_cnt_d = 8'd0;
          // A NOP candidate is never presented as valid; it only runs the drain window.
          if (inst_in[6:0] == 7'h7F) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end else begin
            state_d = ST_TARGET;
          end
        end
      end
      ST_TARGET: begin
        if (fetch_stall) begin
          if (stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
        end else begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
          issued_d    = 1'b1;
        end
      end
      ST_DRAIN: begin
        issued_d = 1'b0;
        if (drain_cnt_q == 8'd0) state_d = ST_DONE;
        else                     drain_cnt_d = drain_cnt_q - 8'd1;
      end
      default: begin
        if (!start) state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including the candidate latch in IDLE.
    if (abort) begin
      state_d     = ST_IDLE;
      issued_d    = 1'b0;
      target_d    = target_q;
      stall_cnt_d = stall_cnt_q;
      drain_cnt_d = drain_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q     <= ST_IDLE;
      target_q    <= NOP_WORD;
      drain_cnt_q <= 8'd0;
      stall_cnt_q <= 8'd0;
      issued_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      issued_q    <= issued_d;
    end
  end

  assign inst_valid    = (state_q == ST_TARGET);
  assign inst_out      = inst_valid ? target_q : NOP_WORD;
  assign check_window  = (state_q == ST_DRAIN);
  assign target_issued = check_window && issued_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_si_inst_injector.sv
// Randomized self-checking bench for si_inst_injector; expectations come from a
// cycle-index timeline model of a check sequence.
module tb_si_inst_injector;

  localparam int          D   = 16;
  localparam logic [31:0] NOP = 32'h0000_007F;
  localparam logic [31:0] ADD = 32'h0020_8033;
  localparam logic [31:0] LW  = 32'h0000_A083;

  logic        clk = 1'b0;
  logic        reset_x;
  logic        start;
  logic        abort;
  logic [31:0] inst_in;
  logic        fetch_stall;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        target_issued;
  logic        check_window;
  logic        busy;
  logic        done;
  logic [7:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  si_inst_injector #(.DRAIN_CYCLES(D), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset_x(reset_x), .start(start), .abort(abort),
    .inst_in(inst_in), .fetch_stall(fetch_stall), .inst_out(inst_out),
    .inst_valid(inst_valid), .target_issued(target_issued),
    .check_window(check_window), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [44:0] observed();
    return {inst_out, inst_valid, target_issued, check_window, busy, done, stall_cnt};
  endfunction

  function automatic logic [7:0] sat8(input int x);
    return (x > 255) ? 8'd255 : 8'(x);
  endfunction

  function automatic logic [44:0] idle_vec(input logic [7:0] sc);
    return {NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sc};
  endfunction

  // Expected outputs k cycles after the start edge: TARGET for 1+stalls cycles
  // (none for a NOP candidate), then D drain cycles, then DONE.
  function automatic logic [44:0] exp_vec(input int k, input logic [31:0] inst, input int stalls);
    bit is_nop;
    int tlen;
    logic [7:0] sc;
    is_nop = (inst[6:0] == 7'h7F);
    tlen   = is_nop ? 0 : stalls + 1;
    sc     = is_nop ? 8'd0 : sat8(stalls);
    if (k <= tlen)
      return {inst, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, sat8(k - 1)};
    else if (k <= tlen + D)
      return {NOP, 1'b0, (!is_nop && k == tlen + 1), 1'b1, 1'b1, 1'b0, sc};
    else
      return {NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, sc};
  endfunction

  // Full sequence from IDLE; optionally keeps start high through DONE.
  task automatic run_sequence(input string name, input logic [31:0] inst, input int stalls, input bit hold);
    int tlen;
    int errs0;
    logic [44:0] got, exp;
    errs0 = errors;
    tlen = (inst[6:0] == 7'h7F) ? 0 : stalls + 1;
    inst_in = inst;
    start = 1'b1;
    fetch_stall = (stalls > 0);
    tick();
    if (!hold) start = 1'b0;
    for (int k = 1; k <= tlen + D + 1; k++) begin
      inst_in = $urandom;
      got = observed();
      exp = exp_vec(k, inst, stalls);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, exp);
      end
      if (k <= tlen) fetch_stall = (k <= stalls);
      else           fetch_stall = 1'($urandom_range(0, 1));
      if (k <= tlen + D) tick();
    end
    if (hold) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        got = observed();
        exp = exp_vec(tlen + D + 2 + j, inst, stalls);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s held-done %0d: got %h expected %h", name, j, got, exp);
        end
      end
      start = 1'b0;
    end
    tick();
    got = observed();
    exp = idle_vec((inst[6:0] == 7'h7F) ? 8'd0 : sat8(stalls));
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s return-idle: got %h expected %h", name, got, exp);
    end
    $display("seq %-12s inst=%h stalls=%0d hold=%0d errors=%0d", name, inst, stalls, hold, errors - errs0);
  endtask

  task automatic test_reset();
    logic [44:0] got;
    reset_x = 1'b0; start = 1'b1; abort = 1'b0; inst_in = ADD; fetch_stall = 1'b0;
    tick(); tick();
    got = observed();
    checks++;
    if (got !== idle_vec(8'd0)) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", got, idle_vec(8'd0));
    end
    reset_x = 1'b1;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_out !== ADD) begin
      errors++;
      $display("FAIL reset_release_valid: got valid=%b out=%h expected valid=1 out=%h", inst_valid, inst_out, ADD);
    end
    begin
      int n;
      n = 0;
      while (!done && n < 100) begin
        tick();
        n++;
      end
      checks++;
      if (n != D + 1) begin
        errors++;
        $display("FAIL reset_seq_len: got %0d cycles to done expected %0d", n, D + 1);
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (observed() !== idle_vec(8'd0)) begin
      errors++;
      $display("FAIL reset_seq_idle: got %h expected %h", observed(), idle_vec(8'd0));
    end
    $display("test_reset done errors=%0d", errors);
  endtask

  task automatic test_abort_drain();
    inst_in = ADD; start = 1'b1; fetch_stall = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (check_window !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_window: got %b expected 1", check_window);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (observed() !== idle_vec(8'd0)) begin
      errors++;
      $display("FAIL abort_drain_idle: got %h expected %h", observed(), idle_vec(8'd0));
    end
    run_sequence("after_abort", LW, $urandom_range(0, 4), 1'b0);
  endtask

  task automatic test_abort_idle();
    inst_in = ADD; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_wins: got busy=%b valid=%b expected 0 0", busy, inst_valid);
    end
    $display("test_abort_idle done errors=%0d", errors);
  endtask

  task automatic test_async_reset();
    inst_in = ADD; start = 1'b1; fetch_stall = 1'b1;
    tick();
    start = 1'b0;
    tick();
    fetch_stall = 1'b0;
    tick(); tick();
    #2 reset_x = 1'b0;
    #1;
    checks++;
    if (observed() !== idle_vec(8'd0)) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", observed(), idle_vec(8'd0));
    end
    tick();
    reset_x = 1'b1;
    tick();
    checks++;
    if (observed() !== idle_vec(8'd0)) begin
      errors++;
      $display("FAIL async_reset_after: got %h expected %h", observed(), idle_vec(8'd0));
    end
    $display("test_async_reset done errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    run_sequence("add_nostall", ADD, 0, 1'b0);
    run_sequence("add_stall5", ADD, 5, 1'b0);
    run_sequence("nop_target", NOP, 0, 1'b0);
    run_sequence("stall_sat", ADD, 300, 1'b0);
    test_abort_drain();
    test_abort_idle();
    run_sequence("hold_done", ADD, 2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[6:0] = 7'h7F;
      run_sequence("random", w, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
